// File: rtl/tap_controller_if.sv
// rtl/tap_controller_if.sv - TMS input and decoded TAP strobes between the controller and its user
// With TAP_STATE_OUT_EN defined, the 4-bit State signal is carried as well.
interface tap_controller_if;
  logic       TMS;
  logic       TapReset;
  logic       CaptureDR;
  logic       ShiftDR;
  logic       UpdateDR;
  logic       ClockDR;
  logic       CaptureIR;
  logic       ShiftIR;
  logic       UpdateIR;
  logic       ClockIR;
  logic       Select;
  logic       Enable;
`ifdef TAP_STATE_OUT_EN
  logic [3:0] State;
`endif

  modport master (
`ifdef TAP_STATE_OUT_EN
    input  State,
`endif
    output TMS,
    input  TapReset, CaptureDR, ShiftDR, UpdateDR, ClockDR,
    input  CaptureIR, ShiftIR, UpdateIR, ClockIR, Select, Enable
  );

  modport slave (
`ifdef TAP_STATE_OUT_EN
    output State,
`endif
    input  TMS,
    output TapReset, CaptureDR, ShiftDR, UpdateDR, ClockDR,
    output CaptureIR, ShiftIR, UpdateIR, ClockIR, Select, Enable
  );
endinterface

// File: rtl/tap_controller.sv
// rtl/tap_controller.sv - IEEE 1149.1 TAP state machine with Moore-decoded scan strobes
// Optional State output is enabled by defining TAP_STATE_OUT_EN.
module tap_controller (
  input  logic              TCK,
  input  logic              Reset,
  tap_controller_if.slave   tap
);

  typedef enum logic [3:0] {
    EXIT2_DR   = 4'h0,
    EXIT1_DR   = 4'h1,
    SHIFT_DR   = 4'h2,
    PAUSE_DR   = 4'h3,
    SELECT_IR  = 4'h4,
    UPDATE_DR  = 4'h5,
    CAPTURE_DR = 4'h6,
    SELECT_DR  = 4'h7,
    EXIT2_IR   = 4'h8,
    EXIT1_IR   = 4'h9,
    SHIFT_IR   = 4'hA,
    PAUSE_IR   = 4'hB,
    RUN_IDLE   = 4'hC,
    UPDATE_IR  = 4'hD,
    CAPTURE_IR = 4'hE,
    TEST_RESET = 4'hF
  } state_e;

  state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      TEST_RESET: state_d = tap.TMS ? TEST_RESET : RUN_IDLE;
      RUN_IDLE:   state_d = tap.TMS ? SELECT_DR  : RUN_IDLE;
      SELECT_DR:  state_d = tap.TMS ? SELECT_IR  : CAPTURE_DR;
      CAPTURE_DR: state_d = tap.TMS ? EXIT1_DR   : SHIFT_DR;
      SHIFT_DR:   state_d = tap.TMS ? EXIT1_DR   : SHIFT_DR;
      EXIT1_DR:   state_d = tap.TMS ? UPDATE_DR  : PAUSE_DR;
      PAUSE_DR:   state_d = tap.TMS ? EXIT2_DR   : PAUSE_DR;
      EXIT2_DR:   state_d = tap.TMS ? UPDATE_DR  : SHIFT_DR;
      UPDATE_DR:  state_d = tap.TMS ? SELECT_DR  : RUN_IDLE;
      SELECT_IR:  state_d = tap.TMS ? TEST_RESET : CAPTURE_IR;
      CAPTURE_IR: state_d = tap.TMS ? EXIT1_IR   : SHIFT_IR;
      SHIFT_IR:   state_d = tap.TMS ? EXIT1_IR   : SHIFT_IR;
      EXIT1_IR:   state_d = tap.TMS ? UPDATE_IR  : PAUSE_IR;
      PAUSE_IR:   state_d = tap.TMS ? EXIT2_IR   : PAUSE_IR;
      EXIT2_IR:   state_d = tap.TMS ? UPDATE_IR  : SHIFT_IR;
      UPDATE_IR:  state_d = tap.TMS ? SELECT_DR  : RUN_IDLE;
      default:    state_d = TEST_RESET;
    endcase
  end

  always_ff @(posedge TCK) begin
    if (Reset) begin
      state_q <= TEST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Every strobe is a decode of state_q alone, so it changes only on TCK edges.
  assign tap.TapReset  = (state_q == TEST_RESET);
  assign tap.CaptureDR = (state_q == CAPTURE_DR);
  assign tap.ShiftDR   = (state_q == SHIFT_DR);
  assign tap.UpdateDR  = (state_q == UPDATE_DR);
  assign tap.ClockDR   = (state_q == CAPTURE_DR) || (state_q == SHIFT_DR);
  assign tap.CaptureIR = (state_q == CAPTURE_IR);
  assign tap.ShiftIR   = (state_q == SHIFT_IR);
  assign tap.UpdateIR  = (state_q == UPDATE_IR);
  assign tap.ClockIR   = (state_q == CAPTURE_IR) || (state_q == SHIFT_IR);
  assign tap.Enable    = (state_q == SHIFT_DR) || (state_q == SHIFT_IR);
  assign tap.Select    = (state_q == SELECT_IR) || (state_q == CAPTURE_IR) ||
                         (state_q == SHIFT_IR)  || (state_q == EXIT1_IR)   ||
                         (state_q == PAUSE_IR)  || (state_q == EXIT2_IR)   ||
                         (state_q == UPDATE_IR);

`ifdef TAP_STATE_OUT_EN
  assign tap.State = state_q;
`endif

endmodule

// File: tb/tb_tap_controller.sv
// tb/tb_tap_controller.sv - directed and table-model checks of the TAP controller
module tb_tap_controller;
  logic TCK;
  logic Reset;
  int   n_checks;
  int   n_fail;

  tap_controller_if bus ();
  tap_controller u_dut (.TCK(TCK), .Reset(Reset), .tap(bus));

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  // Reference: IEEE transition table indexed by state code, plus output rules.
  int  nxt0 [16];
  int  nxt1 [16];
  int  m_state;
  bit  m_valid;

  initial begin
    nxt0 = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
    nxt1 = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};
  end

  // Order: TapReset CaptureDR ShiftDR UpdateDR ClockDR CaptureIR ShiftIR UpdateIR ClockIR Select Enable
  function automatic logic [10:0] model_outs(input int s);
    bit ir_col;
    ir_col = (s == 4) || (s == 8) || (s == 9) || (s == 10) || (s == 11) || (s == 13) || (s == 14);
    return {s == 15, s == 6, s == 2, s == 5, (s == 6) || (s == 2),
            s == 14, s == 10, s == 13, (s == 14) || (s == 10), ir_col,
            (s == 2) || (s == 10)};
  endfunction

  function automatic logic [10:0] dut_outs();
    return {bus.TapReset, bus.CaptureDR, bus.ShiftDR, bus.UpdateDR, bus.ClockDR,
            bus.CaptureIR, bus.ShiftIR, bus.UpdateIR, bus.ClockIR, bus.Select, bus.Enable};
  endfunction

  always @(posedge TCK) begin
    if (Reset) begin
      m_state = 15;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_state = bus.TMS ? nxt1[m_state] : nxt0[m_state];
    end
  end

  always @(negedge TCK) begin
    if (m_valid) begin
      n_checks++;
      if (dut_outs() !== model_outs(m_state)) begin
        n_fail++;
        $display("FAIL model_outs state=%0d got=%b want=%b", m_state, dut_outs(), model_outs(m_state));
      end
`ifdef TAP_STATE_OUT_EN
      n_checks++;
      if (bus.State !== 4'(m_state)) begin
        n_fail++;
        $display("FAIL model_state got=%h want=%h", bus.State, m_state);
      end
`endif
    end
  end

  task automatic step(input bit tms);
    bus.TMS = tms;
    @(posedge TCK);
    #2;
  endtask

  task automatic chk(input string name, input logic [10:0] got, input logic [10:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  task automatic chk_state(input string name, input logic [3:0] want);
`ifdef TAP_STATE_OUT_EN
    n_checks++;
    if (bus.State !== want) begin
      n_fail++;
      $display("FAIL %s state got=%h want=%h", name, bus.State, want);
    end
`else
    chk(name, {10'b0, bus.TapReset}, {10'b0, want == 4'hF});
`endif
  endtask

  // Literal output vectors for the states the directed sequences visit.
  localparam logic [10:0] O_TLR   = 11'b100_0000_0000;
  localparam logic [10:0] O_NONE  = 11'b000_0000_0000;
  localparam logic [10:0] O_CAPDR = 11'b010_0100_0000;
  localparam logic [10:0] O_SHDR  = 11'b001_0100_0001;
  localparam logic [10:0] O_UPDR  = 11'b000_1000_0000;
  localparam logic [10:0] O_SELIR = 11'b000_0000_0010;
  localparam logic [10:0] O_CAPIR = 11'b000_0010_0110;
  localparam logic [10:0] O_SHIR  = 11'b000_0001_0111;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_valid  = 1'b0;
    m_state  = 15;
    bus.TMS  = 1'b0;
    Reset    = 1'b0;
    step(0); step(1); step(0);
    Reset = 1'b1;
    step(0);
    chk("reset_outs", dut_outs(), O_TLR);
    chk_state("reset_state", 4'hF);
    Reset = 1'b0;

    step(0); chk_state("rti", 4'hC); chk("rti_outs", dut_outs(), O_NONE);
    step(1); chk_state("sel_dr", 4'h7);
    step(0); chk("capture_dr", dut_outs(), O_CAPDR);
    step(0); chk("shift_dr_1", dut_outs(), O_SHDR);
    for (int i = 0; i < 3; i++) begin
      step(0); chk("shift_dr_hold", dut_outs(), O_SHDR);
    end
    step(1); chk_state("exit1_dr", 4'h1); chk("exit1_dr_outs", dut_outs(), O_NONE);
    step(1); chk("update_dr", dut_outs(), O_UPDR);
    step(0); chk_state("rti_after_upd", 4'hC); chk("rti_after_upd_outs", dut_outs(), O_NONE);

    step(1); step(1); chk("select_ir", dut_outs(), O_SELIR);
    step(0); chk("capture_ir", dut_outs(), O_CAPIR);
    step(0); chk("shift_ir", dut_outs(), O_SHIR);

    for (int i = 0; i < 4; i++) step(1);
    chk_state("four_ones_sel_ir", 4'h4);
    step(1); chk("five_ones_tlr", dut_outs(), O_TLR);

    step(0); step(1); step(0); step(0);
    chk("pause_entry_shift", dut_outs(), O_SHDR);
    step(1); chk_state("pause_exit1", 4'h1);
    step(0); chk("pause_dr_1", dut_outs(), O_NONE); chk_state("pause_dr_1s", 4'h3);
    step(0); chk("pause_dr_2", dut_outs(), O_NONE);
    step(1); chk_state("exit2_dr", 4'h0);
    step(0); chk("pause_back_shift", dut_outs(), O_SHDR);

    Reset = 1'b1;
    step(0); chk("reset_mid_scan", dut_outs(), O_TLR);
    Reset = 1'b0;

    // Random TMS walk, checked only by the model, with a periodic 5-ones check.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)));
      if (i % 50 == 49) begin
        for (int k = 0; k < 5; k++) step(1);
        chk("five_ones_from_any", dut_outs(), O_TLR);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
